serial_link_tag_sched: RTL and testbench

- Credit-aware scheduler in front of the serial link's data-link TX path.
- Arbitrates round-robin among four tagged AXI-channel requesters (AW, W, AR, R). It multiplexes the winner into a one-entry output register tagged with tag_e.
- Consumes one peer credit per accepted beat and reclaims credits returned by the peer.
- Holds the grant on W for the length of a burst, so W beats of one burst are never interleaved with other W traffic.

---
 rtl/serial_link_pkg.sv | 43 ++++
 rtl/serial_link_tag_sched_if.sv | 25 ++
 rtl/serial_link_rr_arb.sv | 61 ++++++
 rtl/serial_link_tag_sched.sv | 138 +++++++++++++
 tb/tb_serial_link_tag_sched.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_link_pkg.sv
// Shared types for the serial link TX path: credits, beat tags, send state
// and the requester index used by the tag scheduler.
package serial_link_pkg;

    localparam int NumCredits  = 8;
    localparam int NumReq      = 4;
    localparam int CreditWidth = $clog2(NumCredits + 1);

    typedef logic [CreditWidth-1:0] credit_t;
    typedef logic [CreditWidth:0]   credit_ext_t;

    typedef enum logic [3:0] {
        TagIdle = 4'd0,
        TagAW   = 4'd1,
        TagW    = 4'd2,
        TagAR   = 4'd3,
        TagR    = 4'd4
    } tag_e;

    typedef enum logic [1:0] {
        LinkSendIdle = 2'd0,
        LinkSendBusy = 2'd1
    } link_state_e;

    typedef enum logic [1:0] {
        ReqAW = 2'd0,
        ReqW  = 2'd1,
        ReqAR = 2'd2,
        ReqR  = 2'd3
    } req_idx_e;

    function automatic tag_e reqToTag(req_idx_e idx);
        tag_e tag;
        case (idx)
            ReqAW:   tag = TagAW;
            ReqW:    tag = TagW;
            ReqAR:   tag = TagAR;
            default: tag = TagR;
        endcase
        return tag;
    endfunction

endpackage

// File: rtl/serial_link_tag_sched_if.sv
// Requester-side and output-side beat handshakes of the tag scheduler.
interface serial_link_tag_sched_if
    import serial_link_pkg::*;
#(
    parameter int DataWidth = 64
);
    logic [NumReq-1:0]           req_valid_i;
    logic [NumReq-1:0]           req_ready_o;
    logic [NumReq*DataWidth-1:0] req_data_i;
    logic [NumReq-1:0]           req_last_i;
    logic                        out_valid_o;
    logic                        out_ready_i;
    tag_e                        out_tag_o;
    logic [DataWidth-1:0]        out_data_o;

    modport master (
        output req_valid_i, req_data_i, req_last_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_tag_o, out_data_o
    );

    modport slave (
        input  req_valid_i, req_data_i, req_last_i, out_ready_i,
        output req_ready_o, out_valid_o, out_tag_o, out_data_o
    );
endinterface

// File: rtl/serial_link_rr_arb.sv
// Four-way round-robin arbiter. lock_i restricts the grant to W; keepPtr_i
// parks the pointer on the winner instead of moving past it.
module serial_link_rr_arb
    import serial_link_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    input  logic              allow_i,
    input  logic              lock_i,
    input  logic              advance_i,
    input  logic              keepPtr_i,
    output logic [NumReq-1:0] gnt_o,
    output req_idx_e          winner_o
);

    logic [1:0] ptrQ;
    logic [1:0] ptrD;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        gnt_o    = '0;
        winner_o = ReqAW;
        found    = 1'b0;
        idx      = '0;
        if (allow_i) begin
            if (lock_i) begin
                if (req_i[ReqW]) begin
                    gnt_o[ReqW] = 1'b1;
                    winner_o    = ReqW;
                end
            end else begin
                for (int k = 0; k < NumReq; k++) begin
                    idx = ptrQ + 2'(k);
                    if (!found && req_i[idx]) begin
                        found      = 1'b1;
                        gnt_o[idx] = 1'b1;
                        winner_o   = req_idx_e'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        ptrD = ptrQ;
        if (advance_i) begin
            ptrD = keepPtr_i ? 2'(winner_o) : 2'(winner_o) + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptrQ <= '0;
        end else begin
            ptrQ <= ptrD;
        end
    end

endmodule

// File: rtl/serial_link_tag_sched.sv
// Credit-aware AW/W/AR/R scheduler feeding a one-entry tagged output register.
//   state        | meaning
//   LinkSendIdle | any requester may win, gated by en_i
//   LinkSendBusy | mid W burst, only W may win
module serial_link_tag_sched
    import serial_link_pkg::*;
#(
    parameter int DataWidth = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          en_i,
    serial_link_tag_sched_if.slave        bus,
    input  logic                          credit_ret_valid_i,
    input  credit_t                       credit_ret_cnt_i,
    output credit_t                       credits_o,
    output logic                          credit_err_o,
    output link_state_e                   state_o
);

    link_state_e          stateQ, stateD;
    credit_t              creditsQ, creditsD;
    logic                 creditErrQ;
    credit_ext_t          creditSum;
    logic                 creditOvf;
    logic                 outValidQ;
    tag_e                 outTagQ;
    logic [DataWidth-1:0] outDataQ;
    logic [DataWidth-1:0] winData;
    logic [NumReq-1:0]    gnt;
    req_idx_e             winner;
    logic                 slotFree;
    logic                 allowGrant;
    logic                 accept;
    logic                 keepPtr;
    logic                 unusedLast;

    assign unusedLast = ^{bus.req_last_i[ReqAW], bus.req_last_i[ReqAR], bus.req_last_i[ReqR]};

    assign slotFree   = !outValidQ || bus.out_ready_i;
    assign allowGrant = slotFree && (creditsQ != '0) && ((stateQ == LinkSendBusy) || en_i);
    assign accept     = |gnt;

    serial_link_rr_arb u_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (bus.req_valid_i),
        .allow_i   (allowGrant),
        .lock_i    (stateQ == LinkSendBusy),
        .advance_i (accept),
        .keepPtr_i (keepPtr),
        .gnt_o     (gnt),
        .winner_o  (winner)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stateQ <= LinkSendIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // A W beat without last opens a burst; the pointer stays on W until it closes.
    always_comb begin
        stateD  = stateQ;
        keepPtr = 1'b0;
        case (stateQ)
            LinkSendIdle: begin
                if (accept && (winner == ReqW) && !bus.req_last_i[ReqW]) begin
                    stateD  = LinkSendBusy;
                    keepPtr = 1'b1;
                end
            end
            LinkSendBusy: begin
                if (accept) begin
                    if (bus.req_last_i[ReqW]) begin
                        stateD = LinkSendIdle;
                    end else begin
                        keepPtr = 1'b1;
                    end
                end
            end
            default: stateD = LinkSendIdle;
        endcase
    end

    // One spare bit so an over-return is seen before it wraps.
    always_comb begin
        creditSum = credit_ext_t'(creditsQ) - credit_ext_t'(accept)
                  + (credit_ret_valid_i ? credit_ext_t'(credit_ret_cnt_i) : '0);
        creditOvf = creditSum > credit_ext_t'(NumCredits);
        creditsD  = creditOvf ? credit_t'(NumCredits) : creditSum[CreditWidth-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            creditsQ   <= credit_t'(NumCredits);
            creditErrQ <= 1'b0;
        end else begin
            creditsQ   <= creditsD;
            creditErrQ <= creditErrQ | creditOvf;
        end
    end

    always_comb begin
        winData = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (gnt[i]) begin
                winData = bus.req_data_i[i*DataWidth +: DataWidth];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outValidQ <= 1'b0;
            outTagQ   <= TagIdle;
            outDataQ  <= '0;
        end else if (accept) begin
            outValidQ <= 1'b1;
            outTagQ   <= reqToTag(winner);
            outDataQ  <= winData;
        end else if (bus.out_ready_i) begin
            outValidQ <= 1'b0;
            outTagQ   <= TagIdle;
        end
    end

    assign bus.req_ready_o = gnt;
    assign bus.out_valid_o = outValidQ;
    assign bus.out_tag_o   = outTagQ;
    assign bus.out_data_o  = outDataQ;
    assign credits_o       = creditsQ;
    assign credit_err_o    = creditErrQ;
    assign state_o         = stateQ;

endmodule

// File: tb/tb_serial_link_tag_sched.sv
// Directed and randomized checks of serial_link_tag_sched against a
// cycle-level behavioural model of the scheduling rules.
module tb_serial_link_tag_sched;
    import serial_link_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en = 1'b0;
    logic        retValid = 1'b0;
    credit_t     retCnt = '0;
    credit_t     credits;
    logic        credErr;
    link_state_e state;

    int tests = 0;
    int fails = 0;

    logic [63:0] dat [4];

    int          mCred, mPtr, mTag;
    bit          mBusy, mOutValid, mErr;
    logic [63:0] mData;
    logic [3:0]  expReady, obsReady;

    serial_link_tag_sched_if #(.DataWidth(64)) ifc ();

    serial_link_tag_sched #(.DataWidth(64)) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .en_i               (en),
        .bus                (ifc.slave),
        .credit_ret_valid_i (retValid),
        .credit_ret_cnt_i   (retCnt),
        .credits_o          (credits),
        .credit_err_o       (credErr),
        .state_o            (state)
    );

    always #5 clk_i = ~clk_i;

    function automatic int model_winner();
        if (mCred == 0) return -1;
        if (mOutValid && !ifc.out_ready_i) return -1;
        if (mBusy) return ifc.req_valid_i[1] ? 1 : -1;
        if (!en) return -1;
        for (int k = 0; k < 4; k++) begin
            if (ifc.req_valid_i[(mPtr + k) % 4]) return (mPtr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_update(int w);
        int c;
        if (w >= 0) begin
            mOutValid = 1;
            mTag      = w + 1;
            mData     = dat[w];
        end else if (ifc.out_ready_i) begin
            mOutValid = 0;
            mTag      = 0;
        end
        if (w == 1) begin
            if (!ifc.req_last_i[1]) begin
                mBusy = 1;
                mPtr  = 1;
            end else begin
                mBusy = 0;
                mPtr  = 2;
            end
        end else if (w >= 0) begin
            mPtr = (w + 1) % 4;
        end
        c = mCred - ((w >= 0) ? 1 : 0) + (retValid ? int'(retCnt) : 0);
        if (c > NumCredits) begin
            c    = NumCredits;
            mErr = 1;
        end
        mCred = c;
    endtask

    function automatic logic [79:0] exp_vec();
        return {expReady, 1'(mOutValid), 4'(mTag), 4'(mCred), 1'(mErr), 2'(mBusy),
                mOutValid ? mData : 64'h0};
    endfunction

    function automatic logic [79:0] obs_vec();
        return {obsReady, ifc.out_valid_o, 4'(ifc.out_tag_o), 4'(credits), credErr, 2'(state),
                ifc.out_valid_o ? ifc.out_data_o : 64'h0};
    endfunction

    // Inputs are driven at the falling edge; ready is sampled 1ns later,
    // registered outputs at the following falling edge.
    task automatic step();
        int w;
        ifc.req_data_i = {dat[3], dat[2], dat[1], dat[0]};
        w = model_winner();
        expReady = (w < 0) ? 4'b0 : 4'(1 << w);
        #1;
        obsReady = ifc.req_ready_o;
        @(posedge clk_i);
        model_update(w);
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        ifc.req_valid_i = '0;
        ifc.req_last_i  = '0;
        ifc.out_ready_i = 1'b1;
        retValid        = 1'b0;
        retCnt          = '0;
        en              = 1'b1;
        for (int i = 0; i < 4; i++) dat[i] = {$urandom, $urandom};
        ifc.req_data_i  = {dat[3], dat[2], dat[1], dat[0]};
    endtask

    task automatic model_reset();
        mCred = NumCredits; mPtr = 0; mTag = 0;
        mBusy = 0; mOutValid = 0; mErr = 0; mData = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({ifc.out_valid_o, 4'(ifc.out_tag_o), ifc.out_data_o, 4'(credits), credErr, 2'(state)}
            !== {1'b0, 4'd0, 64'h0, 4'd8, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL reset: valid=%0b tag=%0d data=%h cred=%0d err=%0b state=%0d, want 0 0 0 8 0 0",
                     ifc.out_valid_o, ifc.out_tag_o, ifc.out_data_o, credits, credErr, state);
        end
    endtask

    task automatic test_round_robin();
        int want [4] = '{1, 2, 3, 4};
        do_reset();
        ifc.req_valid_i = 4'hF;
        ifc.req_last_i  = 4'hF;
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (obs_vec() !== exp_vec() || int'(ifc.out_tag_o) != want[i]) begin
                fails++;
                $display("FAIL rr_order beat%0d: got %h tag=%0d, want %h tag=%0d", i, obs_vec(),
                         ifc.out_tag_o, exp_vec(), want[i]);
            end
        end
        ifc.req_valid_i = '0;
        tests++;
        if (credits !== 4'd4) begin
            fails++;
            $display("FAIL rr_credits: got %0d want 4", credits);
        end
    endtask

    task automatic test_w_burst();
        logic [3:0] wantReady [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
        logic [1:0] wantState [4] = '{2'd1, 2'd1, 2'd0, 2'd0};
        do_reset();
        ifc.req_valid_i = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            ifc.req_last_i = (i >= 2) ? 4'b0010 : 4'b0000;
            if (i == 3) ifc.req_valid_i = 4'b0100;
            step();
            tests++;
            if (obsReady !== wantReady[i] || 2'(state) !== wantState[i] || obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL w_burst beat%0d: ready=%b state=%0d, want ready=%b state=%0d",
                         i, obsReady, state, wantReady[i], wantState[i]);
            end
        end
        ifc.req_valid_i = '0;
    endtask

    task automatic test_credit_exhaust();
        logic [3:0] wantReady [4] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000};
        do_reset();
        ifc.req_valid_i = 4'b1000;
        repeat (8) step();
        tests++;
        if (credits !== 4'd0) begin
            fails++;
            $display("FAIL exhaust_credits: got %0d want 0", credits);
        end
        for (int i = 0; i < 4; i++) begin
            retValid = (i == 0);
            retCnt   = (i == 0) ? credit_t'(2) : credit_t'(0);
            step();
            tests++;
            if (obsReady !== wantReady[i] || obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL exhaust_resume%0d: ready=%b want %b cred=%0d", i, obsReady, wantReady[i], credits);
            end
        end
        retValid = 1'b0;
        ifc.req_valid_i = '0;
    endtask

    task automatic test_credit_saturate();
        do_reset();
        ifc.req_valid_i = 4'b0001;
        step();
        retValid = 1'b1; retCnt = credit_t'(1);
        step();
        tests++;
        if (credits !== 4'd7 || credErr !== 1'b0) begin
            fails++;
            $display("FAIL sat_simul: cred=%0d err=%0b want 7 0", credits, credErr);
        end
        ifc.req_valid_i = '0;
        retCnt = credit_t'(3);
        step();
        tests++;
        if (credits !== 4'd8 || credErr !== 1'b1) begin
            fails++;
            $display("FAIL sat_over: cred=%0d err=%0b want 8 1", credits, credErr);
        end
        retValid = 1'b0;
        step();
        tests++;
        if (credErr !== 1'b1 || obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL sat_sticky: err=%0b want 1", credErr);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] held;
        do_reset();
        ifc.out_ready_i = 1'b0;
        ifc.req_valid_i = 4'b0001;
        step();
        held = dat[0];
        ifc.req_valid_i = 4'hF;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 4; j++) dat[j] = {$urandom, $urandom};
            step();
            tests++;
            if ({obsReady, ifc.out_valid_o, 4'(ifc.out_tag_o), ifc.out_data_o, 4'(credits)}
                !== {4'b0, 1'b1, 4'd1, held, 4'd7}) begin
                fails++;
                $display("FAIL backpressure%0d: ready=%b tag=%0d data=%h cred=%0d, want 0 1 %h 7",
                         i, obsReady, ifc.out_tag_o, ifc.out_data_o, credits, held);
            end
        end
        ifc.req_valid_i = '0;
        ifc.out_ready_i = 1'b1;
    endtask

    task automatic test_en_mid_burst();
        logic [3:0] wantReady [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0, 4'b0, 4'b0, 4'b0001};
        do_reset();
        ifc.req_valid_i = 4'b0010;
        for (int i = 0; i < 7; i++) begin
            en = (i == 0 || i == 6);
            ifc.req_last_i = (i == 2) ? 4'b0010 : 4'b0000;
            if (i == 3) ifc.req_valid_i = 4'b0011;
            step();
            tests++;
            if (obsReady !== wantReady[i] || obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL en_burst%0d: ready=%b want %b", i, obsReady, wantReady[i]);
            end
        end
        ifc.req_valid_i = '0;
        en = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        ifc.req_valid_i = 4'b0010;
        repeat (2) step();
        rst_ni = 1'b0;
        #2;
        tests++;
        if ({ifc.out_valid_o, 4'(ifc.out_tag_o), 4'(credits), 2'(state)} !== {1'b0, 4'd0, 4'd8, 2'd0}) begin
            fails++;
            $display("FAIL reset_mid: valid=%0b tag=%0d cred=%0d state=%0d want 0 0 8 0",
                     ifc.out_valid_o, ifc.out_tag_o, credits, state);
        end
        clear_inputs();
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ifc.req_valid_i = 4'($urandom);
            ifc.req_last_i  = 4'($urandom_range(0, 15));
            ifc.out_ready_i = ($urandom_range(0, 3) != 0);
            en              = ($urandom_range(0, 7) != 0);
            retValid        = ($urandom_range(0, 4) == 0);
            retCnt          = credit_t'($urandom_range(0, 2));
            for (int j = 0; j < 4; j++) dat[j] = {$urandom, $urandom};
            step();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_round_robin();
        test_w_burst();
        test_credit_exhaust();
        test_credit_saturate();
        test_backpressure();
        test_en_mid_burst();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
